// File: rtl/memory_arbiter.sv
// memory_arbiter
//   Shares one memory port between the instruction-cache and data-cache
//   refill/write-through ports. Grant is registered and round-robin. The
//   owner keeps the grant while it keeps requesting, but after MAX_BEATS
//   completed beats it yields at a beat boundary if the other master waits.
//
// Parameters
//   MAX_BEATS : beats an owner may complete while the other master waits (>= 1)
//   CNT_BITS  : beat counter width, 2**CNT_BITS > MAX_BEATS
//
// Ports
//   clk, rst                : clock, synchronous active-high reset
//   icache_mem_*            : I-cache read port (level request, ready per beat)
//   dcache_mem_*            : D-cache read/write port (level request, ready per beat)
//   mem_*                   : shared memory port
//   grant_owner             : 00 idle, 01 I-cache, 10 D-cache
module memory_arbiter #(
   parameter int MAX_BEATS = 4,
   parameter int CNT_BITS  = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] icache_mem_address,
   input  logic        icache_mem_request,
   output logic [31:0] icache_mem_read_data,
   output logic        icache_mem_ready,
   input  logic [31:0] dcache_mem_address,
   input  logic [31:0] dcache_mem_write_data,
   input  logic [3:0]  dcache_mem_byte_enable,
   input  logic        dcache_mem_write_enable,
   input  logic        dcache_mem_request,
   output logic [31:0] dcache_mem_read_data,
   output logic        dcache_mem_ready,
   output logic [31:0] mem_address,
   output logic [31:0] mem_write_data,
   output logic [3:0]  mem_byte_enable,
   output logic        mem_write_enable,
   output logic        mem_request,
   input  logic [31:0] mem_read_data,
   input  logic        mem_ready,
   output logic [1:0]  grant_owner
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'b00,
      S_GRANT_I = 2'b01,
      S_GRANT_D = 2'b10
   } state_t;

   localparam logic [CNT_BITS-1:0] LP_LAST_BEAT = CNT_BITS'(MAX_BEATS - 1);

   state_t              r_state;
   logic                r_last_owner;   // 0 = I-cache, 1 = D-cache
   logic [CNT_BITS-1:0] r_beat_cnt;

   // Beat counter advance, holding at the last permitted beat so a lone
   // owner can stream indefinitely and still yield on its next beat once
   // the other master shows up.
   function automatic logic [CNT_BITS-1:0] f_beat_next(input logic [CNT_BITS-1:0] cnt);
      return (cnt == LP_LAST_BEAT) ? cnt : cnt + CNT_BITS'(1);
   endfunction

   assign grant_owner = r_state;

   // Memory-side mux and ready/read-data return. A ready is only forwarded
   // while the owner still requests, so a stray mem_ready is ignored.
   always_comb begin
      mem_address          = '0;
      mem_write_data       = '0;
      mem_byte_enable      = '0;
      mem_write_enable     = 1'b0;
      mem_request          = 1'b0;
      icache_mem_ready     = 1'b0;
      icache_mem_read_data = '0;
      dcache_mem_ready     = 1'b0;
      dcache_mem_read_data = '0;
      case (r_state)
         S_GRANT_I: begin
            mem_request          = icache_mem_request;
            mem_address          = icache_mem_address;
            mem_byte_enable      = 4'b1111;
            icache_mem_ready     = mem_ready & icache_mem_request;
            icache_mem_read_data = mem_read_data;
         end
         S_GRANT_D: begin
            mem_request          = dcache_mem_request;
            mem_address          = dcache_mem_address;
            mem_write_data       = dcache_mem_write_data;
            mem_byte_enable      = dcache_mem_byte_enable;
            mem_write_enable     = dcache_mem_write_enable;
            dcache_mem_ready     = mem_ready & dcache_mem_request;
            dcache_mem_read_data = mem_read_data;
         end
         default: ;
      endcase
   end

   // Grant FSM. Ownership only changes when the owner drops its request or
   // at a completed beat once the beat budget is used up.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_last_owner <= 1'b0;   // I counts as last owner, so a first tie goes to D
         r_beat_cnt   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (icache_mem_request && dcache_mem_request)
                  r_state <= r_last_owner ? S_GRANT_I : S_GRANT_D;
               else if (icache_mem_request)
                  r_state <= S_GRANT_I;
               else if (dcache_mem_request)
                  r_state <= S_GRANT_D;
            end
            S_GRANT_I: begin
               if (!icache_mem_request) begin
                  r_state      <= dcache_mem_request ? S_GRANT_D : S_IDLE;
                  r_last_owner <= 1'b0;
                  r_beat_cnt   <= '0;
               end else if (mem_ready) begin
                  if (r_beat_cnt == LP_LAST_BEAT && dcache_mem_request) begin
                     r_state      <= S_GRANT_D;
                     r_last_owner <= 1'b0;
                     r_beat_cnt   <= '0;
                  end else begin
                     r_beat_cnt <= f_beat_next(r_beat_cnt);
                  end
               end
            end
            S_GRANT_D: begin
               if (!dcache_mem_request) begin
                  r_state      <= icache_mem_request ? S_GRANT_I : S_IDLE;
                  r_last_owner <= 1'b1;
                  r_beat_cnt   <= '0;
               end else if (mem_ready) begin
                  if (r_beat_cnt == LP_LAST_BEAT && icache_mem_request) begin
                     r_state      <= S_GRANT_I;
                     r_last_owner <= 1'b1;
                     r_beat_cnt   <= '0;
                  end else begin
                     r_beat_cnt <= f_beat_next(r_beat_cnt);
                  end
               end
            end
            default: begin
               r_state    <= S_IDLE;
               r_beat_cnt <= '0;
            end
         endcase
      end
   end

endmodule
